// File: rtl/foc_sequencer.sv
// foc_sequencer: per-PWM-period controller for the current-loop front end.
// On each accepted trigger it launches Clarke and CORDIC together, waits for
// both completions under a timeout, fires Park and captures its D/Q result
// after a fixed latency.
//
// Ports:
//   clk, rstb                 clock, asynchronous active-low reset
//   enable, trig              frame trigger, accepted only while enable is high
//   clear_fault               leaves the fault state
//   clarke_start/cordic_start launch pulses, clarke_done/cordic_done completions
//   park_start                Park launch pulse
//   d_in, q_in                Park D/Q result, sampled PARK_LAT cycles after park_start
//   d_out, q_out, frame_done  captured D/Q and the update strobe
//   busy, fault, overrun_cnt  status: frame in flight, sticky timeout, lost triggers
module foc_sequencer #(
  parameter int D_WIDTH        = 18,
  parameter int PARK_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 7
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      enable,
  input  logic                      trig,
  input  logic                      clear_fault,
  output logic                      clarke_start,
  output logic                      cordic_start,
  input  logic                      clarke_done,
  input  logic                      cordic_done,
  output logic                      park_start,
  input  logic signed [D_WIDTH-1:0] d_in,
  input  logic signed [D_WIDTH-1:0] q_in,
  output logic signed [D_WIDTH-1:0] d_out,
  output logic signed [D_WIDTH-1:0] q_out,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      fault,
  output logic [7:0]                overrun_cnt
);

  localparam int LW = (PARK_LAT > 1) ? $clog2(PARK_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_PARK,
    S_SETTLE,
    S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic          got_clarke, got_clarke_nxt;
  logic          got_cordic, got_cordic_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [LW-1:0] lat_cnt, lat_cnt_nxt;
  logic          capture;
  logic          trig_ok;

  logic          launch_nxt;
  logic          park_start_nxt;
  logic          busy_nxt;
  logic          fault_nxt;
  logic [7:0]    overrun_nxt;

  assign trig_ok = trig & enable;

  // State register; the output flops are loaded from the next-state decode so
  // every output changes together with the state it belongs to.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= S_IDLE;
      got_clarke   <= 1'b0;
      got_cordic   <= 1'b0;
      timer        <= '0;
      lat_cnt      <= '0;
      clarke_start <= 1'b0;
      cordic_start <= 1'b0;
      park_start   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      frame_done   <= 1'b0;
      overrun_cnt  <= '0;
      d_out        <= '0;
      q_out        <= '0;
    end else begin
      state        <= state_nxt;
      got_clarke   <= got_clarke_nxt;
      got_cordic   <= got_cordic_nxt;
      timer        <= timer_nxt;
      lat_cnt      <= lat_cnt_nxt;
      clarke_start <= launch_nxt;
      cordic_start <= launch_nxt;
      park_start   <= park_start_nxt;
      busy         <= busy_nxt;
      fault        <= fault_nxt;
      frame_done   <= capture;
      overrun_cnt  <= overrun_nxt;
      if (capture) begin
        d_out <= d_in;
        q_out <= q_in;
      end
    end
  end

  // Next-state logic, including completion flags, timeout timer and the
  // Park latency counter.
  always_comb begin
    state_nxt      = state;
    got_clarke_nxt = got_clarke;
    got_cordic_nxt = got_cordic;
    timer_nxt      = timer;
    lat_cnt_nxt    = lat_cnt;
    capture        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (trig_ok) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Flags restart here, but a done arriving in this very cycle counts.
        got_clarke_nxt = clarke_done;
        got_cordic_nxt = cordic_done;
        timer_nxt      = '0;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        got_clarke_nxt = got_clarke | clarke_done;
        got_cordic_nxt = got_cordic | cordic_done;
        timer_nxt      = timer + 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (got_clarke_nxt && got_cordic_nxt) begin
          state_nxt = S_PARK;
        end else if (timer_nxt == TW'(TIMEOUT_CYCLES)) begin
          state_nxt = S_ERR;
        end
      end
      S_PARK: begin
        lat_cnt_nxt = '0;
        if (PARK_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        lat_cnt_nxt = lat_cnt + 1'b1;
        if (lat_cnt == LW'(PARK_LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (clear_fault) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: values the output flops take at the next edge.
  always_comb begin
    launch_nxt     = (state_nxt == S_LAUNCH);
    park_start_nxt = (state_nxt == S_PARK);
    busy_nxt       = !(state_nxt inside {S_IDLE, S_ERR});
    fault_nxt      = (state_nxt == S_ERR);
    overrun_nxt    = overrun_cnt;
    // A trigger is lost only while a frame is in flight; ERR drops it silently.
    if (trig_ok && (state inside {S_LAUNCH, S_WAIT, S_PARK, S_SETTLE}) &&
        (overrun_cnt != 8'hFF)) begin
      overrun_nxt = overrun_cnt + 8'd1;
    end
  end

endmodule
